// File: rtl/maze_level_ctrl.sv
// maze_level_ctrl
// Game-flow sequencer sitting directly upstream of the maze counter. It decides
// when the displayed maze changes (clear on new game / after a win, increment on
// a debounced exit), repositions the player, and tells the renderer which screen
// to draw.
//
// State  | meaning
// -------+---------------------------------------------------------------
// TITLE  | title screen, waiting for a start-key press
// PLAY   | maze active, player may move, exit tile debounced per frame
// TRANS  | level-transition screen, counts TRANS_FRAMES frame ticks
// WIN    | final maze solved, waiting for a start-key press
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   frame_tick   one-cycle pulse per video frame
//   start_key    start button (already synchronised), level sensitive
//   exit_hit     high while the player stands on the exit tile
//   level        current maze index read back from the maze counter
//   maze_clr     one-cycle pulse, clears the maze counter
//   maze_inc     one-cycle pulse, increments the maze counter
//   player_reset one-cycle pulse, move player to the maze start tile
//   move_en      player movement permitted (PLAY only)
//   screen_sel   0=TITLE, 1=PLAY, 2=TRANSITION, 3=WIN
module maze_level_ctrl #(
    parameter int NUM_LEVELS      = 5,
    parameter int LEVEL_W         = 3,
    parameter int TRANS_FRAMES    = 60,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_key,
    input  logic               exit_hit,
    input  logic [LEVEL_W-1:0] level,
    output logic               maze_clr,
    output logic               maze_inc,
    output logic               player_reset,
    output logic               move_en,
    output logic [1:0]         screen_sel
);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_TRANS = 2'd2,
        S_WIN   = 2'd3
    } state_t;

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [3:0]         DEB_TARGET = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0]         TRANS_LOAD = 8'(TRANS_FRAMES);

    state_t     state, state_next;
    logic [3:0] dbc, dbc_next;
    logic [7:0] timer, timer_next;
    logic       start_prev;
    logic       clr_next, inc_next, prst_next;
    logic       start_rise;
    logic       final_level;

    assign start_rise  = start_key & ~start_prev;
    // Out-of-range levels are treated as the final maze.
    assign final_level = (level >= LAST_LEVEL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_TITLE;
            dbc          <= '0;
            timer        <= '0;
            // Key held through reset must not look like a fresh press.
            start_prev   <= 1'b1;
            maze_clr     <= 1'b0;
            maze_inc     <= 1'b0;
            player_reset <= 1'b0;
        end else begin
            state        <= state_next;
            dbc          <= dbc_next;
            timer        <= timer_next;
            start_prev   <= start_key;
            maze_clr     <= clr_next;
            maze_inc     <= inc_next;
            player_reset <= prst_next;
        end
    end

    always_comb begin
        state_next = state;
        dbc_next   = dbc;
        timer_next = timer;
        clr_next   = 1'b0;
        inc_next   = 1'b0;
        prst_next  = 1'b0;

        case (state)
            S_TITLE: begin
                // A coincident frame tick is deliberately ignored here.
                if (start_rise) begin
                    clr_next   = 1'b1;
                    prst_next  = 1'b1;
                    dbc_next   = '0;
                    state_next = S_PLAY;
                end
            end

            S_PLAY: begin
                if (frame_tick) begin
                    if (exit_hit) begin
                        if ((dbc + 4'd1) >= DEB_TARGET) begin
                            dbc_next = '0;
                            if (final_level) begin
                                state_next = S_WIN;
                            end else begin
                                inc_next   = 1'b1;
                                timer_next = TRANS_LOAD;
                                state_next = S_TRANS;
                            end
                        end else begin
                            dbc_next = dbc + 4'd1;
                        end
                    end else begin
                        dbc_next = '0;
                    end
                end
            end

            S_TRANS: begin
                if (frame_tick) begin
                    // Zero is only reachable with an illegal TRANS_FRAMES; leave anyway.
                    if (timer <= 8'd1) begin
                        timer_next = '0;
                        prst_next  = 1'b1;
                        dbc_next   = '0;
                        state_next = S_PLAY;
                    end else begin
                        timer_next = timer - 8'd1;
                    end
                end
            end

            S_WIN: begin
                // No player_reset here; the next TITLE->PLAY issues it.
                if (start_rise) begin
                    clr_next   = 1'b1;
                    state_next = S_TITLE;
                end
            end

            default: begin
                state_next = S_TITLE;
            end
        endcase
    end

    assign screen_sel = state;
    assign move_en    = (state == S_PLAY);

endmodule

// File: doc/maze_level_ctrl.md
Name: maze_level_ctrl

Overview:
- Game-flow sequencer that decides when the displayed maze changes.
- Directly upstream of the maze counter: drives that counter's clear and increment inputs from title/play/transition/win game flow, and reads back the current level.
- Debounces the player's "on exit tile" indication against the frame tick.
- Generates player-reposition pulses, a screen-select code for the renderer, and a movement-enable flag.

Parameters:
- NUM_LEVELS, 5, number of mazes; level NUM_LEVELS-1 is the final maze.
- LEVEL_W, 3, width of level input; must satisfy 2^LEVEL_W >= NUM_LEVELS.
- TRANS_FRAMES, 60, frame ticks spent on the level-transition screen; legal range 1..255.
- DEBOUNCE_FRAMES, 2, consecutive frame ticks exit_hit must be high to count as a level exit; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync).
- start_key  in  1  level-sensitive start button, already synchronised.
- exit_hit  in  1  high while player occupies the current maze's exit tile.
- level  in  LEVEL_W  current maze index fed back from the maze counter.
- maze_clr  out  1  one-cycle pulse to the maze counter clear input.
- maze_inc  out  1  one-cycle pulse to the maze counter increment input.
- player_reset  out  1  one-cycle pulse: reposition player to maze start tile.
- move_en  out  1  player movement permitted.
- screen_sel  out  2  0=TITLE, 1=PLAY, 2=TRANSITION, 3=WIN.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state and outputs update on the posedge of clk only.
- Reset values: state TITLE, maze_clr=0, maze_inc=0, player_reset=0, move_en=0, screen_sel=0, debounce count=0, transition timer=0, start_prev=1.
- start_prev=1 at reset means a key held through reset does not register as a press.
- Start edge: start_rise = start_key & ~start_prev; start_prev <= start_key every cycle.
- Outputs are registered. Each pulse is high for exactly one cycle, the cycle after the edge on which its triggering condition was sampled. Pulse and state change occur on the same edge.
- screen_sel and move_en are decoded from the registered state. move_en=1 only in PLAY.
- TITLE:
  - On start_rise: assert maze_clr and player_reset; go to PLAY.
- PLAY:
  - On each frame_tick: if exit_hit=1, debounce count increments, saturating at DEBOUNCE_FRAMES; if exit_hit=0, count clears to 0.
  - exit_hit is ignored between frame ticks.
  - When the count reaches DEBOUNCE_FRAMES on a frame_tick:
    - If level >= NUM_LEVELS-1: go to WIN; no maze_inc.
    - Otherwise: assert maze_inc, load timer with TRANS_FRAMES, go to TRANSITION.
  - Debounce count clears on every exit from PLAY.
  - start_key is ignored in PLAY.
- TRANSITION:
  - move_en=0.
  - Timer decrements on each frame_tick.
  - On the frame_tick that brings the timer from 1 to 0: assert player_reset; go to PLAY.
  - Dwell is therefore exactly TRANS_FRAMES frame ticks.
  - start_key and exit_hit are ignored.
- WIN:
  - On start_rise: assert maze_clr; go to TITLE.
  - No player_reset is issued on this path; TITLE→PLAY issues it.
- maze_inc and maze_clr are never asserted in the same cycle. At most one maze_inc is issued per PLAY visit.
- Out-of-range level (>= NUM_LEVELS) is treated as the final level.
- Simultaneous frame_tick and start_rise in TITLE or WIN: start_rise is acted on; the tick has no effect.
- Reset mid-operation, in any state or mid-pulse: all registers take reset values on that edge; any pulse in flight is dropped.

Test Plan:
Parameter set for all scenarios: NUM_LEVELS=3, TRANS_FRAMES=4, DEBOUNCE_FRAMES=2.
- Start from reset: hold start_key=1 through reset release, keep high 10 cycles, then drop and raise.
  → No pulse while held from reset. On the raise, maze_clr and player_reset pulse 1 cycle; screen_sel goes 0→1; move_en=1.
- Level advance: in PLAY with level=0, exit_hit=1 across two frame_ticks.
  → maze_inc pulses once, the cycle after the second tick; screen_sel=2; move_en=0. After 4 more ticks, player_reset pulses; screen_sel=1.
- Debounce glitch: exit_hit high at one tick, low at the next, high at the following.
  → No maze_inc; state stays PLAY. Two further consecutive high ticks → maze_inc pulses.
- Final level: level=2, two high ticks.
  → screen_sel=3, no maze_inc, move_en=0. Then start_rise → maze_clr pulse; screen_sel=0.
- Reset mid-transition: reset asserted after 2 of 4 transition ticks.
  → All outputs return to reset values next cycle. The remaining ticks produce no player_reset.
- Ignored inputs: start_rise during PLAY and TRANSITION, exit_hit during TRANSITION, and a frame_tick coinciding with start_rise in TITLE.
  → No spurious pulses. Only the TITLE start_rise takes effect.
